// File: rtl/occ_arbiter_if.sv
// Requester-side bus of the rom_Occ arbiter: flattened request/address inputs and
// shared grant/response outputs.
interface occ_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*ADDR_W-1:0] addr1_i;
    logic [N_REQ*ADDR_W-1:0] addr2_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]       rdata1_o;
    logic [DATA_W-1:0]       rdata2_o;
    logic                    busy_o;

    modport master (
        output req_i, addr1_i, addr2_i,
        input  gnt_o, rvalid_o, rdata1_o, rdata2_o, busy_o
    );

    modport slave (
        input  req_i, addr1_i, addr2_i,
        output gnt_o, rvalid_o, rdata1_o, rdata2_o, busy_o
    );
endinterface

// File: rtl/occ_arbiter.sv
// Round-robin arbiter sharing one dual-port combinational rom_Occ among N_REQ requesters.
// Each access takes an ISSUE cycle (rom driven) followed by a RESP cycle (data returned).
module occ_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    occ_arbiter_if.slave      bus,
    output logic              ce_rom_Occ_o,
    output logic [ADDR_W-1:0] addr1_rom_Occ_o,
    output logic [ADDR_W-1:0] addr2_rom_Occ_o,
    input  logic [DATA_W-1:0] data_1_i,
    input  logic [DATA_W-1:0] data_2_i
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  win_q;
    logic [ADDR_W-1:0] a1_q;
    logic [ADDR_W-1:0] a2_q;

    logic [IDX_W-1:0]  pick;
    logic              found;

    // Scan downward from the farthest offset so the nearest request to rr_ptr wins last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            int               sum;
            logic [IDX_W-1:0] idx;
            sum = int'(rr_ptr_q) + i;
            if (sum >= int'(N_REQ)) sum = sum - int'(N_REQ);
            idx = sum[IDX_W-1:0];
            if (bus.req_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            a1_q         <= '0;
            a2_q         <= '0;
            bus.gnt_o    <= '0;
            bus.rvalid_o <= '0;
            bus.rdata1_o <= '0;
            bus.rdata2_o <= '0;
        end else begin
            bus.gnt_o    <= '0;
            bus.rvalid_o <= '0;
            case (state_q)
                StIssue: begin
                    state_q      <= StResp;
                    bus.rvalid_o <= N_REQ'(1) << win_q;
                    bus.rdata1_o <= data_1_i;
                    bus.rdata2_o <= data_2_i;
                end
                default: begin
                    if (found) begin
                        state_q   <= StIssue;
                        win_q     <= pick;
                        a1_q      <= bus.addr1_i[pick*ADDR_W +: ADDR_W];
                        a2_q      <= bus.addr2_i[pick*ADDR_W +: ADDR_W];
                        rr_ptr_q  <= (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + IDX_W'(1);
                        bus.gnt_o <= N_REQ'(1) << pick;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    // rom controls decode straight from the state register so reset clears them at once.
    assign ce_rom_Occ_o    = (state_q == StIssue);
    assign addr1_rom_Occ_o = (state_q == StIssue) ? a1_q : '0;
    assign addr2_rom_Occ_o = (state_q == StIssue) ? a2_q : '0;
    assign bus.busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_occ_arbiter.sv
// Self-checking bench for occ_arbiter: directed scenarios plus a randomized run
// against a transaction-level round-robin reference model.
module tb_occ_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          ce;
    logic [AW-1:0] ra1o, ra2o;
    logic [DW-1:0] d1, d2;
    logic [AW-1:0] ra1 [N];
    logic [AW-1:0] ra2 [N];
    int            n_vec = 0;
    int            n_err = 0;

    occ_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    occ_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .ce_rom_Occ_o    (ce),
        .addr1_rom_Occ_o (ra1o),
        .addr2_rom_Occ_o (ra2o),
        .data_1_i        (d1),
        .data_2_i        (d2)
    );

    function automatic logic [DW-1:0] rom1(input logic [AW-1:0] a);
        return {a, 8'hA5, ~a, a ^ 8'h3C};
    endfunction

    function automatic logic [DW-1:0] rom2(input logic [AW-1:0] a);
        return {~a, a, 8'h5A, a + 8'd7};
    endfunction

    assign d1 = rom1(ra1o);
    assign d2 = rom2(ra2o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r);
        bus.req_i = r;
        for (int k = 0; k < int'(N); k++) begin
            bus.addr1_i[k*AW +: AW] = ra1[k];
            bus.addr2_i[k*AW +: AW] = ra2[k];
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive('0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        n_vec++;
        if ({bus.gnt_o, bus.rvalid_o, bus.busy_o, ce, ra1o, ra2o, bus.rdata1_o, bus.rdata2_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b busy=%b ce=%b a1=%h a2=%h rd1=%h rd2=%h, want all 0",
                     bus.gnt_o, bus.rvalid_o, bus.busy_o, ce, ra1o, ra2o, bus.rdata1_o, bus.rdata2_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single;
        ra1[0] = 8'h10; ra2[0] = 8'h20;
        drive(4'b0001);
        tick();
        n_vec++;
        if ({bus.gnt_o, ce, ra1o, ra2o, bus.rvalid_o, bus.busy_o} !== {4'b0001, 1'b1, 8'h10, 8'h20, 4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL single_issue: got gnt=%b ce=%b a1=%h a2=%h rvalid=%b busy=%b, want 0001 1 10 20 0000 1",
                     bus.gnt_o, ce, ra1o, ra2o, bus.rvalid_o, bus.busy_o);
        end
        drive(4'b0000);
        tick();
        n_vec++;
        if ({bus.rvalid_o, bus.gnt_o, ce} !== {4'b0001, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL single_resp: got rvalid=%b gnt=%b ce=%b, want 0001 0000 0", bus.rvalid_o, bus.gnt_o, ce);
        end
        n_vec++;
        if ({bus.rdata1_o, bus.rdata2_o} !== {rom1(8'h10), rom2(8'h20)}) begin
            n_err++;
            $display("FAIL single_rdata: got %h/%h, want %h/%h", bus.rdata1_o, bus.rdata2_o, rom1(8'h10), rom2(8'h20));
        end
        tick();
        n_vec++;
        if ({bus.rvalid_o, bus.busy_o} !== 5'b0) begin
            n_err++;
            $display("FAIL single_idle: got rvalid=%b busy=%b, want 0000 0", bus.rvalid_o, bus.busy_o);
        end
    endtask

    task automatic test_fairness;
        logic [N-1:0] exp_g;
        do_reset();
        drive(4'b1111);
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_g = (c % 2 == 1) ? (N'(1) << (((c - 1) / 2) % int'(N))) : '0;
            n_vec++;
            if ({bus.gnt_o, bus.busy_o} !== {exp_g, 1'b1}) begin
                n_err++;
                $display("FAIL fairness_c%0d: got gnt=%b busy=%b, want gnt=%b busy=1", c, bus.gnt_o, bus.busy_o, exp_g);
            end
        end
        drive(4'b0000);
        tick();
        tick();
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] eg [5];
        logic [N-1:0] ev [5];
        eg = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
        ev = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
        do_reset();
        drive(4'b1010);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if ({bus.gnt_o, bus.rvalid_o} !== {eg[c], ev[c]}) begin
                n_err++;
                $display("FAIL back_to_back_c%0d: got gnt=%b rvalid=%b, want gnt=%b rvalid=%b",
                         c, bus.gnt_o, bus.rvalid_o, eg[c], ev[c]);
            end
        end
        drive(4'b0000);
        tick();
        tick();
    endtask

    task automatic test_addr_latch;
        ra1[2] = 8'h33; ra2[2] = 8'h44;
        drive(4'b0100);
        tick();
        ra1[2] = 8'hFF;
        drive(4'b0000);
        #1;
        n_vec++;
        if ({bus.gnt_o, ra1o, ra2o} !== {4'b0100, 8'h33, 8'h44}) begin
            n_err++;
            $display("FAIL addr_latch: got gnt=%b a1=%h a2=%h, want 0100 33 44", bus.gnt_o, ra1o, ra2o);
        end
        tick();
        n_vec++;
        if ({bus.rvalid_o, bus.rdata1_o, bus.rdata2_o} !== {4'b0100, rom1(8'h33), rom2(8'h44)}) begin
            n_err++;
            $display("FAIL addr_latch_rdata: got rvalid=%b rd1=%h rd2=%h, want 0100 %h %h",
                     bus.rvalid_o, bus.rdata1_o, bus.rdata2_o, rom1(8'h33), rom2(8'h44));
        end
        tick();
    endtask

    task automatic test_rst_mid_access;
        do_reset();
        drive(4'b0010);
        tick();
        drive(4'b0000);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.gnt_o, bus.rvalid_o, bus.busy_o, ce, ra1o, ra2o, bus.rdata1_o, bus.rdata2_o} !== '0) begin
            n_err++;
            $display("FAIL rst_async: got gnt=%b rvalid=%b busy=%b ce=%b a1=%h a2=%h, want all 0",
                     bus.gnt_o, bus.rvalid_o, bus.busy_o, ce, ra1o, ra2o);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if ({bus.rvalid_o, bus.gnt_o, bus.busy_o} !== 9'b0) begin
                n_err++;
                $display("FAIL rst_no_resp_c%0d: got rvalid=%b gnt=%b busy=%b, want 0", c, bus.rvalid_o, bus.gnt_o, bus.busy_o);
            end
        end
        drive(4'b0101);
        tick();
        n_vec++;
        if (bus.gnt_o !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_scan_from_0: got gnt=%b, want 0001", bus.gnt_o);
        end
        drive(4'b0000);
        tick();
        tick();
    endtask

    task automatic test_drop_in_issue;
        drive(4'b1000);
        tick();
        n_vec++;
        if (bus.gnt_o !== 4'b1000) begin
            n_err++;
            $display("FAIL drop_gnt: got gnt=%b, want 1000", bus.gnt_o);
        end
        drive(4'b0000);
        tick();
        n_vec++;
        if ({bus.rvalid_o, bus.busy_o} !== {4'b1000, 1'b1}) begin
            n_err++;
            $display("FAIL drop_rvalid: got rvalid=%b busy=%b, want 1000 1", bus.rvalid_o, bus.busy_o);
        end
        tick();
        n_vec++;
        if ({bus.rvalid_o, bus.busy_o} !== 5'b0) begin
            n_err++;
            $display("FAIL drop_idle: got rvalid=%b busy=%b, want 0000 0", bus.rvalid_o, bus.busy_o);
        end
    endtask

    // Reference model: an access occupies two cycles; a new winner is chosen whenever
    // the previous cycle did not start an access, scanning round-robin from m_ptr.
    task automatic test_random;
        logic [N-1:0]  r, e_gnt, e_rv;
        logic [DW-1:0] e_rd1, e_rd2;
        logic [AW-1:0] m_a1, m_a2, e_ra1, e_ra2;
        logic          e_ce, e_busy;
        bit            m_issue, found;
        int            m_ptr, m_win;
        do_reset();
        r = '0; e_gnt = '0; e_rv = '0; e_rd1 = '0; e_rd2 = '0;
        m_a1 = '0; m_a2 = '0; m_issue = 0; m_ptr = 0; m_win = 0;
        for (int k = 0; k < int'(N); k++) begin
            ra1[k] = 8'($urandom); ra2[k] = 8'($urandom);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < int'(N); k++) begin
                if (e_gnt[k]) begin
                    r[k] = 1'($urandom_range(1, 0));
                    ra1[k] = 8'($urandom); ra2[k] = 8'($urandom);
                end else if (!r[k] && $urandom_range(3, 0) == 0) begin
                    r[k] = 1'b1;
                    ra1[k] = 8'($urandom); ra2[k] = 8'($urandom);
                end
            end
            drive(r);
            e_gnt = '0; e_rv = '0; e_ce = 1'b0; e_ra1 = '0; e_ra2 = '0; e_busy = 1'b0;
            if (m_issue) begin
                e_rv = N'(1) << m_win;
                e_rd1 = rom1(m_a1);
                e_rd2 = rom2(m_a2);
                e_busy = 1'b1;
                m_issue = 0;
            end else begin
                found = 0;
                for (int i = 0; i < int'(N); i++) begin
                    if (!found && r[(m_ptr + i) % int'(N)]) begin
                        found = 1;
                        m_win = (m_ptr + i) % int'(N);
                    end
                end
                if (found) begin
                    m_a1 = ra1[m_win]; m_a2 = ra2[m_win];
                    m_ptr = (m_win + 1) % int'(N);
                    e_gnt = N'(1) << m_win;
                    e_ce = 1'b1; e_ra1 = m_a1; e_ra2 = m_a2; e_busy = 1'b1;
                    m_issue = 1;
                end
            end
            tick();
            n_vec++;
            if ({bus.gnt_o, bus.rvalid_o, bus.rdata1_o, bus.rdata2_o, bus.busy_o, ce, ra1o, ra2o} !==
                {e_gnt, e_rv, e_rd1, e_rd2, e_busy, e_ce, e_ra1, e_ra2}) begin
                n_err++;
                $display("FAIL random_c%0d: got gnt=%b rv=%b rd=%h/%h busy=%b ce=%b a=%h/%h, want gnt=%b rv=%b rd=%h/%h busy=%b ce=%b a=%h/%h",
                         cyc, bus.gnt_o, bus.rvalid_o, bus.rdata1_o, bus.rdata2_o, bus.busy_o, ce, ra1o, ra2o,
                         e_gnt, e_rv, e_rd1, e_rd2, e_busy, e_ce, e_ra1, e_ra2);
            end
        end
        drive('0);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            ra1[k] = '0; ra2[k] = '0;
        end
        drive('0);
        #3 rst = 1'b1;
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_addr_latch();
        test_rst_mid_access();
        test_drop_in_issue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
